// File: rtl/hex_print_pkg.sv
// hex_print_pkg: shared states and ASCII constants for the hex line printer
package hex_print_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, SEP, DATA, CR, LF} state_t;
    localparam logic [7:0] CHAR_COLON       = 8'h3A;
    localparam logic [7:0] CHAR_CR          = 8'h0D;
    localparam logic [7:0] CHAR_LF          = 8'h0A;
    localparam logic [7:0] ASCII_ZERO       = 8'h30;
    localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: maps a 4-bit value to its uppercase ASCII hex digit
module nibble_to_ascii
    import hex_print_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    assign ascii = (nib < 4'd10) ? ASCII_ZERO + {4'h0, nib} : ASCII_A_MINUS_10 + {4'h0, nib};
endmodule

// File: rtl/hex_print_sequencer.sv
// hex_print_sequencer: prints one address/data event as an ASCII hex line on a byte stream
module hex_print_sequencer
    import hex_print_pkg::*;
#(
    parameter int ADDR_NIBBLES = 4,
    parameter int DATA_NIBBLES = 2,
    parameter int EOL_CRLF     = 1,
    localparam int AW = (ADDR_NIBBLES > 0) ? 4 * ADDR_NIBBLES : 1,
    localparam int DW = 4 * DATA_NIBBLES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          busy
);
    localparam logic [7:0] EOL_CHAR = (EOL_CRLF != 0) ? CHAR_CR : CHAR_LF;
    state_t state, state_n;
    logic [AW-1:0] addr_sr;
    logic [DW-1:0] data_sr;
    logic [2:0] cnt, cnt_n;
    logic [3:0] nib, addr_top, req_addr_top;
    logic [7:0] asc, char_n;
    logic accept, fire, last;
    assign req_ready = rst_n && state == IDLE;
    assign tx_valid  = state != IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
    assign fire      = tx_valid && tx_ready;
    assign last      = cnt == 3'd1;
    generate
        if (ADDR_NIBBLES > 0) begin : g_addr
            assign addr_top     = addr_sr[AW-1-:4];
            assign req_addr_top = req_addr[AW-1-:4];
        end else begin : g_noaddr
            assign addr_top     = 4'h0;
            assign req_addr_top = 4'h0;
        end
    endgenerate
    // shift registers hold only the digits not yet presented
    assign nib = (state == IDLE) ? ((ADDR_NIBBLES > 0) ? req_addr_top : req_data[DW-1-:4]) :
                 (state == ADDR && !last) ? addr_top : data_sr[DW-1-:4];
    nibble_to_ascii u_n2a (.nib(nib), .ascii(asc));
    always_comb begin
        state_n = state;
        char_n  = tx_data;
        cnt_n   = fire ? cnt - 3'd1 : cnt;
        case (state)
            IDLE: if (accept) begin
                state_n = (ADDR_NIBBLES > 0) ? ADDR : DATA;
                char_n  = asc;
                cnt_n   = (ADDR_NIBBLES > 0) ? 3'(ADDR_NIBBLES) : 3'(DATA_NIBBLES);
            end
            ADDR: if (fire) begin
                state_n = last ? SEP : ADDR;
                char_n  = last ? CHAR_COLON : asc;
            end
            SEP: if (fire) begin
                state_n = DATA;
                char_n  = asc;
                cnt_n   = 3'(DATA_NIBBLES);
            end
            DATA: if (fire) begin
                state_n = !last ? DATA : (EOL_CRLF != 0) ? CR : LF;
                char_n  = last ? EOL_CHAR : asc;
            end
            CR: if (fire) begin
                state_n = LF;
                char_n  = CHAR_LF;
            end
            LF: if (fire) begin
                state_n = IDLE;
                char_n  = 8'h00;
            end
            default: begin
                state_n = IDLE;
                char_n  = 8'h00;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_data <= 8'h00;
            cnt     <= 3'd0;
            addr_sr <= '0;
            data_sr <= '0;
        end else begin
            state   <= state_n;
            tx_data <= char_n;
            cnt     <= cnt_n;
            if (accept) begin
                addr_sr <= req_addr << 4;
                data_sr <= (ADDR_NIBBLES > 0) ? req_data : req_data << 4;
            end else begin
                if (fire && state == ADDR)
                    addr_sr <= addr_sr << 4;
                if (fire && (state == SEP || (state == DATA && !last)))
                    data_sr <= data_sr << 4;
            end
        end
    end
endmodule

// File: tb/tb_hex_print_sequencer.sv
// tb_hex_print_sequencer: randomized and directed checks against a line-queue model
module tb_hex_print_sequencer;
    typedef logic [7:0] ch_t;
    typedef ch_t bq_t[$];
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_valid1 = 1'b0, tx_ready = 1'b1;
    logic [15:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [0:0] req_addr1 = '0;
    logic [3:0] req_data1 = '0;
    logic req_ready0, tx_valid0, busy0, req_ready1, tx_valid1, busy1;
    logic [7:0] tx_data0, tx_data1;
    int total = 0, bad = 0;
    bq_t q0, q1, log0, log1;
    bit rst_edge;
    always #5 clk = ~clk;
    hex_print_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .req_data(req_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .tx_data(tx_data0), .busy(busy0)
    );
    hex_print_sequencer #(.ADDR_NIBBLES(0), .DATA_NIBBLES(1), .EOL_CRLF(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .req_data(req_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .tx_data(tx_data1), .busy(busy1)
    );
    function automatic bq_t make_line(int a, int d, int an, int dn, bit crlf);
        string hex = "0123456789ABCDEF";
        bq_t r;
        for (int i = an - 1; i >= 0; i--) r.push_back(hex[(a >> (4 * i)) & 15]);
        if (an > 0) r.push_back(":");
        for (int i = dn - 1; i >= 0; i--) r.push_back(hex[(d >> (4 * i)) & 15]);
        if (crlf) r.push_back(8'h0D);
        r.push_back(8'h0A);
        return r;
    endfunction
    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_line(string name, bq_t act, bq_t exp);
        total++;
        if (act.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_len: got %0d want %0d", name, act.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) chk(name, i < act.size() ? act[i] : 8'hxx, exp[i]);
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("idle_timeout", 8'(q0.size() + q1.size()), 8'd0);
    endtask
    task automatic send0(logic [15:0] a, logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    // model: a pending line of characters per DUT, front element is what must be shown
    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() != 0) begin
                if (tx_ready) begin
                    log0.push_back(tx_data0);
                    void'(q0.pop_front());
                end
            end else if (req_valid) q0 = make_line(int'(req_addr), int'(req_data), 4, 2, 1'b1);
            if (q1.size() != 0) begin
                if (tx_ready) begin
                    log1.push_back(tx_data1);
                    void'(q1.pop_front());
                end
            end else if (req_valid1) q1 = make_line(0, int'(req_data1), 0, 1, 1'b0);
        end
        rst_edge = !rst_n;
        #1;
        chk("tx_valid", 8'(tx_valid0), 8'(q0.size() != 0));
        chk("busy", 8'(busy0), 8'(q0.size() != 0));
        chk("req_ready", 8'(req_ready0), 8'(rst_n && q0.size() == 0));
        if (q0.size() != 0) chk("tx_data", tx_data0, q0[0]);
        if (rst_edge) chk("tx_data_rst", tx_data0, 8'h00);
        chk("tx_valid1", 8'(tx_valid1), 8'(q1.size() != 0));
        chk("req_ready1", 8'(req_ready1), 8'(rst_n && q1.size() == 0));
        if (q1.size() != 0) chk("tx_data1", tx_data1, q1[0]);
    end
    initial begin
        bq_t ref_line = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h3A, 8'h43, 8'h33, 8'h0D, 8'h0A};
        logic [15:0] sweep_a [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        chk_line("model_pin", make_line(16'h1A2F, 8'hC3, 4, 2, 1'b1), ref_line);
        chk_line("model_pin1", make_line(0, 7, 0, 1, 1'b0), '{8'h37, 8'h0A});
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 8'(req_ready0), 8'h00);
        rst_n = 1'b1;
        log0.delete();
        send0(16'h1A2F, 8'hC3);
        wait_idle();
        chk_line("line_1a2f", log0, ref_line);
        log0.delete();
        send0(16'h1A2F, 8'hC3);
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", tx_data0, 8'h32);
            chk("bp_valid", 8'(tx_valid0), 8'h01);
        end
        tx_ready = 1'b1;
        wait_idle();
        chk_line("line_bp", log0, ref_line);
        foreach (sweep_a[i]) for (int j = 0; j < 2; j++) begin
            send0(sweep_a[i], j ? 8'hFF : 8'h00);
            while (q0.size() != 0) begin
                tx_ready = $urandom_range(0, 2) != 0;
                @(negedge clk);
            end
            tx_ready = 1'b1;
            wait_idle();
        end
        @(negedge clk);
        req_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            req_addr = 16'($urandom); req_data = 8'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();
        send0(16'hBEEF, 8'h5A);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 8'(tx_valid0), 8'h00);
        chk("midrst_data", tx_data0, 8'h00);
        chk("midrst_busy", 8'(busy0), 8'h00);
        rst_n = 1'b1;
        log0.delete();
        send0(16'h0F3C, 8'h9D);
        wait_idle();
        chk_line("line_after_rst", log0, make_line(16'h0F3C, 8'h9D, 4, 2, 1'b1));
        log1.delete();
        @(negedge clk);
        req_valid1 = 1'b1; req_data1 = 4'h7;
        @(negedge clk);
        req_valid1 = 1'b0;
        wait_idle();
        chk_line("line_cfg1", log1, '{8'h37, 8'h0A});
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n = $urandom_range(0, 150) != 0;
            req_valid = $urandom_range(0, 3) == 0;
            req_valid1 = $urandom_range(0, 2) == 0;
            req_addr = 16'($urandom); req_data = 8'($urandom); req_data1 = 4'($urandom);
            tx_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; tx_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
